multicycle_chunk_adder: RTL and testbench
=========================================

Name: multicycle_chunk_adder

Overview:
- Parametrised sequential successor to the combinational ripple-carry adder.
- Adds or subtracts two N-bit operands over N/CHUNK cycles, processing CHUNK bits per cycle and holding the carry in a register between chunks.
- Trades latency for a short critical path (one CHUNK-bit ripple per cycle).
- Uses valid/ready handshakes on input and output, so it slots into the ALU datapath as a pipelined arithmetic unit.

Parameters:
- N, 32, operand/result width in bits.
- CHUNK, 8, bits processed per cycle. N must be an integer multiple of CHUNK; M = N/CHUNK is the chunk count.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous reset, active-high.
- in_valid  input  1  operand bundle valid.
- in_ready  output  1  block can accept operands; equals (state==IDLE).
- A  input  N  operand A.
- B  input  N  operand B.
- sub  input  1  0 = add, 1 = subtract.
- cin  input  1  carry-in (add) or borrow-in (sub).
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- Sum  output  N  result.
- cout  output  1  carry out of MSB (in sub mode: 1 = no borrow).
- ovf  output  1  two's-complement signed overflow.

Behaviour:
- Reset (async, immediate): state=IDLE, chunk index=0, carry reg=0, Sum=0, cout=0, ovf=0, out_valid=0. in_ready=1 while state is IDLE, including during reset.
- Arithmetic: captured Bx = sub ? ~B : B; initial carry = cin ^ sub.
  - sub=0 computes A+B+cin.
  - sub=1 computes A-B-cin.
  - All operations are mod 2^N.
- ovf = carry into MSB XOR carry out of MSB, evaluated on the final chunk.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_valid=1 at an edge: capture A, Bx and initial carry; clear index; go to RUN.
  - Otherwise stay in IDLE.
- RUN: each edge adds chunk idx, i.e. bits [idx*CHUNK +: CHUNK] plus the carry reg.
  - Write the result into the Sum register at the same bit slice.
  - Update the carry reg; idx++.
  - On the edge processing idx=M-1: latch cout and ovf, set out_valid=1, go to DONE.
- Latency: operands accepted at edge t, so out_valid=1 is first observed after edge t+M. For CHUNK=N this is 1 cycle.
- DONE: out_valid, Sum, cout and ovf are held stable while out_ready=0.
  - On an edge with out_ready=1: out_valid→0, go to IDLE.
  - Sum, cout and ovf keep their last values until overwritten by the next operation.
- Inputs A, B, sub, cin and in_valid are ignored in RUN and DONE; operands are captured only at accept.
- Sum is undefined-but-stable during RUN (partial chunks). Consumers sample it only when out_valid=1.
- Throughput: at most one result per M+2 cycles; no input/output overlap.
- Reset mid-RUN or mid-DONE: the operation is aborted, with no partial result or out_valid pulse. After reset deasserts, the first operation behaves identically to post-power-up.
- No combinational path from in_valid to in_ready, or from out_ready to out_valid.
- All outputs except in_ready are registered.
- Elaboration must reject N % CHUNK != 0.

Test Plan:
- Carry ripple across all chunks (N=32, CHUNK=8, add): A=0xFFFFFFFF, B=0x00000001, cin=0 → Sum=0x00000000, cout=1, ovf=0; out_valid rises exactly 4 edges after accept.
- Signed overflow (add): A=0x7FFFFFFF, B=1, cin=0 → Sum=0x80000000, cout=0, ovf=1. Then A=0x00000005, B=0x00000003, cin=1 → Sum=0x00000009, cout=0, ovf=0.
- Subtract: A=5, B=7, sub=1, cin=0 → Sum=0xFFFFFFFE, cout=0, ovf=0. A=0x80000000, B=1, sub=1 → Sum=0x7FFFFFFF, cout=1, ovf=1. A=10, B=3, sub=1, cin=1 → Sum=6, cout=1.
- Backpressure and ignored inputs: hold out_ready=0 for 10 cycles after out_valid, toggling A/B/in_valid meanwhile → out_valid, Sum, cout and ovf stable; in_ready=0 throughout. Raise out_ready → out_valid=0 next edge, in_ready=1, then the next operation is accepted correctly.
- Reset mid-operation: assert rst while idx=2 → Sum=0, cout=0, ovf=0, out_valid=0 immediately (async). Deassert → in_ready=1; a fresh 3+4 gives Sum=7 after 4 edges.
- Parameter sweep: (N=32, CHUNK=32) latency 1; (N=32, CHUNK=1) latency 32; (N=16, CHUNK=4). Run 1000 random operands per configuration, with random sub/cin and random out_ready stalls, checked against a behavioural model of Sum/cout/ovf.

Source files
------------

// File: rtl/multicycle_chunk_adder_if.sv
// multicycle_chunk_adder_if: operand/result valid-ready bundle for multicycle_chunk_adder.
interface multicycle_chunk_adder_if #(parameter int N = 32);
  logic in_valid, in_ready, sub, cin, out_valid, out_ready, cout, ovf;
  logic [N-1:0] a, b, sum;
  modport master (output in_valid, a, b, sub, cin, out_ready, input in_ready, out_valid, sum, cout, ovf);
  modport slave (input in_valid, a, b, sub, cin, out_ready, output in_ready, out_valid, sum, cout, ovf);
endinterface

// File: rtl/multicycle_chunk_adder.sv
// multicycle_chunk_adder: N-bit add/subtract evaluated CHUNK bits per cycle,
// carry held in a register between chunks, valid/ready on both sides.
module multicycle_chunk_adder #(
  parameter int N = 32,
  parameter int CHUNK = 8
) (
  input logic clk,
  input logic rst,
  multicycle_chunk_adder_if.slave bus
);
  localparam int M = N / CHUNK;
  localparam int IW = (M > 1) ? $clog2(M) : 1;
  if (N % CHUNK != 0) begin : g_bad_chunk
    $error("multicycle_chunk_adder: N must be a multiple of CHUNK");
  end
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [N-1:0] a_q, a_d, bx_q, bx_d, sum_q, sum_d;
  logic carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d, out_valid_q, out_valid_d;
  logic [CHUNK-1:0] a_c, b_c, s_c;
  logic c_out, c_msb;
  assign a_c = a_q[idx_q*CHUNK +: CHUNK];
  assign b_c = bx_q[idx_q*CHUNK +: CHUNK];
  assign {c_out, s_c} = {1'b0, a_c} + {1'b0, b_c} + {{CHUNK{1'b0}}, carry_q};
  // carry into the top bit recovered from the sum bit, so no second ripple is needed
  assign c_msb = s_c[CHUNK-1] ^ a_c[CHUNK-1] ^ b_c[CHUNK-1];
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    a_d = a_q;
    bx_d = bx_q;
    carry_d = carry_q;
    sum_d = sum_q;
    cout_d = cout_q;
    ovf_d = ovf_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: if (bus.in_valid) begin
        a_d = bus.a;
        bx_d = bus.sub ? ~bus.b : bus.b;
        carry_d = bus.cin ^ bus.sub;
        idx_d = '0;
        state_d = RUN;
      end
      RUN: begin
        sum_d[idx_q*CHUNK +: CHUNK] = s_c;
        carry_d = c_out;
        idx_d = idx_q + 1'b1;
        if (idx_q == IW'(M - 1)) begin
          cout_d = c_out;
          ovf_d = c_out ^ c_msb;
          out_valid_d = 1'b1;
          state_d = DONE;
        end
      end
      DONE: if (bus.out_ready) begin
        out_valid_d = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q <= '0;
      a_q <= '0;
      bx_q <= '0;
      carry_q <= 1'b0;
      sum_q <= '0;
      cout_q <= 1'b0;
      ovf_q <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      a_q <= a_d;
      bx_q <= bx_d;
      carry_q <= carry_d;
      sum_q <= sum_d;
      cout_q <= cout_d;
      ovf_q <= ovf_d;
      out_valid_q <= out_valid_d;
    end
  end
  assign bus.in_ready = (state_q == IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.sum = sum_q;
  assign bus.cout = cout_q;
  assign bus.ovf = ovf_q;
endmodule

// File: tb/tb_multicycle_chunk_adder.sv
// tb_multicycle_chunk_adder: directed vectors on N=32/CHUNK=8 plus random sweeps on other shapes.
module tb_multicycle_chunk_adder;
  logic clk, rst, rst_sw;
  int n_tests = 0, n_fail = 0;
  initial clk = 1'b0;
  always #5 clk = ~clk;
  multicycle_chunk_adder_if #(.N(32)) mb ();
  multicycle_chunk_adder #(.N(32), .CHUNK(8)) dut (.clk(clk), .rst(rst), .bus(mb));
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s, input logic c, output int lat);
    mb.a = a;
    mb.b = b;
    mb.sub = s;
    mb.cin = c;
    mb.in_valid = 1'b1;
    chk("in_ready_idle", 64'(mb.in_ready), 64'd1);
    @(negedge clk);
    mb.in_valid = 1'b0;
    lat = 0;
    while (!mb.out_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
  endtask
  task automatic result(input string tag, input int lat, input logic [31:0] s, input logic co, input logic ov);
    chk({tag, "_lat"}, 64'(lat), 64'd4);
    chk({tag, "_sum"}, 64'(mb.sum), 64'(s));
    chk({tag, "_cout"}, 64'(mb.cout), 64'(co));
    chk({tag, "_ovf"}, 64'(mb.ovf), 64'(ov));
  endtask
  task automatic pop(input string tag);
    mb.out_ready = 1'b1;
    @(negedge clk);
    mb.out_ready = 1'b0;
    chk({tag, "_pop_valid"}, 64'(mb.out_valid), 64'd0);
    chk({tag, "_pop_ready"}, 64'(mb.in_ready), 64'd1);
  endtask
  typedef struct packed {
    logic [31:0] a, b;
    logic s, c;
    logic [31:0] sum;
    logic co, ov;
  } vec_t;
  vec_t vecs[6] = '{
    '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0},
    '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1},
    '{32'h00000005, 32'h00000003, 1'b0, 1'b1, 32'h00000009, 1'b0, 1'b0},
    '{32'h00000005, 32'h00000007, 1'b1, 1'b0, 32'hFFFFFFFE, 1'b0, 1'b0},
    '{32'h80000000, 32'h00000001, 1'b1, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b1},
    '{32'h0000000A, 32'h00000003, 1'b1, 1'b1, 32'h00000006, 1'b1, 1'b0}
  };
  localparam int SN[3] = '{32, 32, 16};
  localparam int SC[3] = '{32, 1, 4};
  for (genvar g = 0; g < 3; g++) begin : g_sw
    localparam int NN = SN[g];
    localparam int CC = SC[g];
    logic done;
    multicycle_chunk_adder_if #(.N(NN)) sb ();
    multicycle_chunk_adder #(.N(NN), .CHUNK(CC)) dut (.clk(clk), .rst(rst_sw), .bus(sb));
    initial begin
      logic [NN-1:0] a, b, bx;
      logic [NN:0] full, cz;
      logic s, c, ov;
      int lat;
      string tg;
      done = 1'b0;
      tg = $sformatf("sw%0d", g);
      sb.in_valid = 1'b0;
      sb.a = '0;
      sb.b = '0;
      sb.sub = 1'b0;
      sb.cin = 1'b0;
      sb.out_ready = 1'b0;
      repeat (2) @(negedge clk);
      for (int i = 0; i < 1000; i++) begin
        a = NN'($urandom);
        b = NN'($urandom);
        s = 1'($urandom);
        c = 1'($urandom);
        bx = s ? ~b : b;
        cz = '0;
        cz[0] = c ^ s;
        full = {1'b0, a} + {1'b0, bx} + cz;
        ov = (a[NN-1] == bx[NN-1]) && (full[NN-1] != a[NN-1]);
        sb.a = a;
        sb.b = b;
        sb.sub = s;
        sb.cin = c;
        sb.in_valid = 1'b1;
        chk({tg, "_in_ready"}, 64'(sb.in_ready), 64'd1);
        @(negedge clk);
        sb.in_valid = 1'b0;
        lat = 0;
        while (!sb.out_valid && lat < 200) begin
          @(negedge clk);
          lat++;
        end
        chk({tg, "_lat"}, 64'(lat), 64'(NN / CC));
        repeat ($urandom_range(0, 3)) @(negedge clk);
        chk({tg, "_sum"}, 64'(sb.sum), 64'(full[NN-1:0]));
        chk({tg, "_cout"}, 64'(sb.cout), 64'(full[NN]));
        chk({tg, "_ovf"}, 64'(sb.ovf), 64'(ov));
        sb.out_ready = 1'b1;
        @(negedge clk);
        sb.out_ready = 1'b0;
        chk({tg, "_pop"}, 64'(sb.out_valid), 64'd0);
      end
      done = 1'b1;
    end
  end
  initial begin
    int lat;
    logic all_done;
    mb.in_valid = 1'b0;
    mb.a = '0;
    mb.b = '0;
    mb.sub = 1'b0;
    mb.cin = 1'b0;
    mb.out_ready = 1'b0;
    rst = 1'b0;
    rst_sw = 1'b0;
    #1;
    rst = 1'b1;
    rst_sw = 1'b1;
    #1;
    chk("rst_in_ready", 64'(mb.in_ready), 64'd1);
    chk("rst_out_valid", 64'(mb.out_valid), 64'd0);
    chk("rst_sum", 64'(mb.sum), 64'd0);
    chk("rst_cout", 64'(mb.cout), 64'd0);
    chk("rst_ovf", 64'(mb.ovf), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    rst_sw = 1'b0;
    for (int i = 0; i < 6; i++) begin
      issue(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].c, lat);
      result($sformatf("vec%0d", i), lat, vecs[i].sum, vecs[i].co, vecs[i].ov);
      pop($sformatf("vec%0d", i));
    end
    issue(32'h12345678, 32'h11111111, 1'b0, 1'b0, lat);
    result("bp", lat, 32'h23456789, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      mb.in_valid = i[0];
      mb.a = $urandom;
      mb.b = $urandom;
      mb.sub = i[1];
      @(negedge clk);
      chk("bp_valid", 64'(mb.out_valid), 64'd1);
      chk("bp_sum", 64'(mb.sum), 64'h23456789);
      chk("bp_cout", 64'(mb.cout), 64'd0);
      chk("bp_ovf", 64'(mb.ovf), 64'd0);
      chk("bp_in_ready", 64'(mb.in_ready), 64'd0);
    end
    mb.in_valid = 1'b0;
    pop("bp");
    issue(32'd100, 32'd23, 1'b0, 1'b0, lat);
    result("after_bp", lat, 32'd123, 1'b0, 1'b0);
    pop("after_bp");
    mb.a = 32'h11111111;
    mb.b = 32'h22222222;
    mb.sub = 1'b0;
    mb.cin = 1'b0;
    mb.in_valid = 1'b1;
    @(negedge clk);
    mb.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_sum", 64'(mb.sum), 64'd0);
    chk("midrst_cout", 64'(mb.cout), 64'd0);
    chk("midrst_ovf", 64'(mb.ovf), 64'd0);
    chk("midrst_valid", 64'(mb.out_valid), 64'd0);
    chk("midrst_in_ready", 64'(mb.in_ready), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    issue(32'd3, 32'd4, 1'b0, 1'b0, lat);
    result("post_rst", lat, 32'd7, 1'b0, 1'b0);
    pop("post_rst");
    all_done = 1'b0;
    for (int k = 0; k < 60000 && !all_done; k++) begin
      @(negedge clk);
      all_done = g_sw[0].done && g_sw[1].done && g_sw[2].done;
    end
    chk("sweep_done", 64'(all_done), 64'd1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
